// File: rtl/number_rom_arbiter.sv
// -----------------------------------------------------------------------------
// number_rom_arbiter
//
// Time-shares the single synchronous number ROM (ten 10x10 digit glyphs at
// 100-word strides) among up to four digit renderers. One requester is
// granted per cycle. Its address is registered onto the ROM address bus, and
// the ROM word comes back two cycles after the grant, tagged with the
// winner's index.
//
// Build option:
//   NUMBER_ROM_ARB_FIXED_PRIO_EN - when defined, the lowest requesting index
//   always wins and no last-grant state is kept. Undefined (default) gives
//   round-robin arbitration. Latency and handshake are the same in both
//   builds.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   req        per-requester level request
//   req_addr   packed request addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt        one-hot combinational grant, same cycle as req
//   rom_addr   registered ROM address
//   rom_data   ROM word, valid one cycle after rom_addr is sampled
//   rsp_valid  rsp_data holds a granted word
//   rsp_id     index of the requester that owns rsp_data
//   rsp_data   ROM word passed straight through
//   busy       a grant is still travelling down the response pipeline
// -----------------------------------------------------------------------------
module number_rom_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12,
    parameter int ID_W   = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    output logic [N_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    logic              found;
    logic [ID_W-1:0]   winner;
    logic [ADDR_W-1:0] win_addr;
    logic              transfer;

    logic              s1_valid;
    logic [ID_W-1:0]   s1_id;
    logic              s2_valid;
    logic [ID_W-1:0]   s2_id;

`ifdef NUMBER_ROM_ARB_FIXED_PRIO_EN

    // Fixed priority: scan from the top index down so that the lowest set
    // request is the last one written and therefore wins.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        win_addr = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                found    = 1'b1;
                winner   = ID_W'(i);
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

`else

    logic [ID_W-1:0] last_gnt;

    // Round-robin: the candidate at offset k from last_gnt has priority k,
    // with offset 1 the highest. Scanning offsets from N_REQ down to 1 lets
    // the highest-priority requester be the last one written.
    always_comb begin
        int idx;
        idx      = 0;
        found    = 1'b0;
        winner   = '0;
        win_addr = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_gnt) + k) % N_REQ;
            if (req[idx]) begin
                found    = 1'b1;
                winner   = ID_W'(idx);
                win_addr = req_addr[idx*ADDR_W +: ADDR_W];
            end
        end
    end

    // last_gnt starts at the top index so requester 0 is first after reset,
    // and it moves only when a transfer actually happens.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt <= ID_W'(N_REQ - 1);
        end else if (transfer) begin
            last_gnt <= winner;
        end
    end

`endif

    // While reset is held no grant may be shown, even with requests present,
    // so the grant is gated by reset_n as well as by a request being found.
    always_comb begin
        transfer = found & reset_n;
        gnt      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = transfer && (winner == ID_W'(i));
        end
    end

    // ROM address register: loaded with the winner's address on a transfer
    // and otherwise held, so an idle bus keeps presenting the last address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
        end else if (transfer) begin
            rom_addr <= win_addr;
        end
    end

    // Two-stage {valid, id} shift register matching the address register
    // plus the ROM's own output register. Reset drops anything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_id    <= '0;
        end else begin
            s1_valid <= transfer;
            s1_id    <= winner;
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_id    = s2_id;
    assign rsp_data  = rom_data;
    assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_number_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_number_rom_arbiter
//
// Self-checking bench for number_rom_arbiter with four requesters. A small
// registered ROM model supplies rom_data. A reference model predicts grants
// from an explicit priority list, and a two-entry response delay line
// predicts the tagged ROM words.
// Honours NUMBER_ROM_ARB_FIXED_PRIO_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_number_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 12;
    localparam int IW = 2;

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            busy;

    int tests_run;
    int tests_failed;

    number_rom_arbiter #(
        .N_REQ (N),
        .ADDR_W(AW),
        .DATA_W(DW),
        .ID_W  (IW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rsp_valid(rsp_valid),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data),
        .busy     (busy)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arbitrary but address-dependent ROM contents
    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        logic [DW-1:0] x;
        x = {2'b00, a};
        return (x * 12'd13) ^ 12'h5A5;
    endfunction

    // Synchronous ROM: one cycle from address to data
    always_ff @(posedge clk) begin
        rom_data <= rom_fn(rom_addr);
    end

    // ---------------- reference model ----------------
    int            m_last;
    logic [AW-1:0] m_rom_addr;
    bit            pv[2];
    int            pid[2];
    logic [AW-1:0] pa[2];

    function automatic void modelReset();
        m_last     = N - 1;
        m_rom_addr = '0;
        for (int i = 0; i < 2; i++) begin
            pv[i]  = 1'b0;
            pid[i] = 0;
            pa[i]  = '0;
        end
    endfunction

    // Winner = first requester in the priority list that is asking
    function automatic int modelWinner(input logic [N-1:0] r);
        int order[$];
        if (reset_n !== 1'b1) return -1;
`ifdef NUMBER_ROM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) order.push_back(i);
`else
        for (int s = 1; s <= N; s++) order.push_back((m_last + s) % N);
`endif
        foreach (order[j]) begin
            if (r[order[j]]) return order[j];
        end
        return -1;
    endfunction

    function automatic void modelAdvance(input logic [N-1:0] r, input logic [N*AW-1:0] a);
        int w;
        if (reset_n !== 1'b1) begin
            modelReset();
            return;
        end
        w      = modelWinner(r);
        pv[1]  = pv[0];
        pid[1] = pid[0];
        pa[1]  = pa[0];
        pv[0]  = (w >= 0);
        if (w >= 0) begin
            pid[0]     = w;
            pa[0]      = a[w*AW +: AW];
            m_rom_addr = a[w*AW +: AW];
            m_last     = w;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input logic [N-1:0] r);
        int            w;
        logic [N-1:0]  exp_gnt;
        w       = modelWinner(r);
        exp_gnt = '0;
        if (w >= 0) exp_gnt[w] = 1'b1;
        checkVal("gnt", 32'(gnt), 32'(exp_gnt));
        checkVal("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
        checkVal("rsp_valid", 32'(rsp_valid), 32'(pv[1]));
        checkVal("busy", 32'(busy), 32'(pv[0] | pv[1]));
        if (pv[1]) begin
            checkVal("rsp_id", 32'(rsp_id), 32'(pid[1]));
            checkVal("rsp_data", 32'(rsp_data), 32'(rom_fn(pa[1])));
        end
    endtask

    // Drive one cycle just after the rising edge, check at the falling edge,
    // then advance the model across the next rising edge.
    task automatic applyStimulus(input logic [N-1:0] r, input logic [N*AW-1:0] a,
                                 input logic rst_n, output int w);
        @(posedge clk);
        #1;
        reset_n  = rst_n;
        if (!rst_n) modelReset();
        req      = r;
        req_addr = a;
        @(negedge clk);
        w = modelWinner(r);
        checkOutput(r);
        modelAdvance(r, a);
    endtask

    typedef struct {
        logic [N-1:0] r;
        logic [N-1:0] exp_gnt;
        int           exp_rom;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [N-1:0] r, input logic [N-1:0] g, input int rom);
        vec_t v;
        v.r       = r;
        v.exp_gnt = g;
        v.exp_rom = rom;
        return v;
    endfunction

    initial begin
        int            w;
        logic [N*AW-1:0] tbl_addr;
        logic [N*AW-1:0] single_addr;
        logic [N-1:0]  pending;
        logic [AW-1:0] paddr[N];
        logic [N*AW-1:0] ra;

        tests_run    = 0;
        tests_failed = 0;
        tbl_addr     = {10'd903, 10'd702, 10'd501, 10'd305};
        single_addr  = {10'd11, 10'd305, 10'd22, 10'd33};

        // Requests present during reset must not be granted
        reset_n  = 1'b0;
        req      = 4'b1111;
        req_addr = tbl_addr;
        modelReset();
        applyStimulus(4'b1111, tbl_addr, 1'b0, w);
        applyStimulus(4'b1111, tbl_addr, 1'b0, w);
        checkVal("reset gnt", 32'(gnt), 32'h0);
        checkVal("reset rom_addr", 32'(rom_addr), 32'h0);
        checkVal("reset rsp_valid", 32'(rsp_valid), 32'h0);
        checkVal("reset busy", 32'(busy), 32'h0);

        // Contention, then gap handling, then mixed patterns
`ifdef NUMBER_ROM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 8; i++) vecs.push_back(mk(4'b1111, 4'b0001, -1));
        vecs.push_back(mk(4'b1000, 4'b1000, -1));
        vecs.push_back(mk(4'b0000, 4'b0000, 903));
        vecs.push_back(mk(4'b0000, 4'b0000, 903));
        vecs.push_back(mk(4'b0001, 4'b0001, 903));
        vecs.push_back(mk(4'b0110, 4'b0010, 305));
        vecs.push_back(mk(4'b0110, 4'b0010, -1));
        vecs.push_back(mk(4'b1011, 4'b0001, -1));
`else
        for (int i = 0; i < 8; i++) vecs.push_back(mk(4'b1111, 4'(1 << (i % 4)), -1));
        vecs.push_back(mk(4'b1000, 4'b1000, -1));
        vecs.push_back(mk(4'b0000, 4'b0000, 903));
        vecs.push_back(mk(4'b0000, 4'b0000, 903));
        vecs.push_back(mk(4'b0001, 4'b0001, 903));
        vecs.push_back(mk(4'b0110, 4'b0010, 305));
        vecs.push_back(mk(4'b0110, 4'b0100, -1));
        vecs.push_back(mk(4'b1011, 4'b1000, -1));
`endif
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, tbl_addr, 1'b1, w);
            checkVal("table gnt", 32'(gnt), 32'(vecs[i].exp_gnt));
            if (vecs[i].exp_rom >= 0) checkVal("table rom_addr hold", 32'(rom_addr), 32'(vecs[i].exp_rom));
        end

        // Single requester: grant, address, then tagged word two cycles on
        applyStimulus(4'b0000, single_addr, 1'b1, w);
        applyStimulus(4'b0000, single_addr, 1'b1, w);
        applyStimulus(4'b0100, single_addr, 1'b1, w);
        checkVal("single gnt", 32'(gnt), 32'h4);
        applyStimulus(4'b0000, single_addr, 1'b1, w);
        checkVal("single rom_addr", 32'(rom_addr), 32'd305);
        checkVal("single rsp_valid early", 32'(rsp_valid), 32'h0);
        applyStimulus(4'b0000, single_addr, 1'b1, w);
        checkVal("single rsp_valid", 32'(rsp_valid), 32'h1);
        checkVal("single rsp_id", 32'(rsp_id), 32'd2);
        checkVal("single rsp_data", 32'(rsp_data), 32'(rom_fn(10'd305)));

        // Mid-flight reset drops the in-flight response
        applyStimulus(4'b0010, single_addr, 1'b1, w);
        checkVal("midreset gnt", 32'(gnt), 32'h2);
        applyStimulus(4'b0000, single_addr, 1'b0, w);
        checkVal("midreset busy", 32'(busy), 32'h0);
        checkVal("midreset rsp_valid", 32'(rsp_valid), 32'h0);
        applyStimulus(4'b0000, single_addr, 1'b0, w);
        checkVal("midreset rsp_valid 2", 32'(rsp_valid), 32'h0);
        applyStimulus(4'b0000, single_addr, 1'b1, w);
        checkVal("midreset rsp_valid 3", 32'(rsp_valid), 32'h0);
        applyStimulus(4'b1111, single_addr, 1'b1, w);
        checkVal("post reset gnt", 32'(gnt), 32'h1);

        // Randomised traffic obeying the hold-until-granted handshake
        pending = '0;
        for (int i = 0; i < N; i++) paddr[i] = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pending[i] = 1'b1;
                        paddr[i]   = AW'($urandom_range(0, 1023));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    pending[i] = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) ra[i*AW +: AW] = paddr[i];
            applyStimulus(pending, ra, 1'b1, w);
            if (w >= 0) pending[w] = 1'b0;
        end

        // Drain so the last responses are compared too
        applyStimulus(4'b0000, ra, 1'b1, w);
        applyStimulus(4'b0000, ra, 1'b1, w);
        applyStimulus(4'b0000, ra, 1'b1, w);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/number_rom_arbiter.md
# number_rom_arbiter

Time-shares the single synchronous number ROM, which holds ten 10×10 digit glyphs at 100-word strides, among up to four display requesters, such as the score, high-score and timer digit renderers. Each requester issues a word address with a request/grant handshake. The block grants one requester per cycle, drives the ROM address, and returns the ROM word tagged with the winner's ID at a fixed latency. It sits between the digit-rendering blocks and the one number ROM instance in the top module.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..4.
- ADDR_W, 10: ROM address width.
- DATA_W, 12: ROM word width (RGB444).
- ID_W, 2: width of the requester index, clog2(N_REQ) with a minimum of 1.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset_n, input, 1: reset, asynchronous and active-low.
- req, input, N_REQ: per-requester request, level.
- req_addr, input, N_REQ*ADDR_W: packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- gnt, output, N_REQ: one-hot grant, combinational, same cycle as req.
- rom_addr, output, ADDR_W: registered address to the ROM.
- rom_data, input, DATA_W: ROM output, valid one cycle after rom_addr is sampled.
- rsp_valid, output, 1: rsp_data holds a granted word.
- rsp_id, output, ID_W: index of the requester that owns rsp_data.
- rsp_data, output, DATA_W: equals rom_data, passed through.
- busy, output, 1: a grant is in flight in the pipeline.

## Operation
- Handshake:
  - A requester asserts req[i] with a stable req_addr slice and holds both until it sees gnt[i] high.
  - A transfer occurs in any cycle where req[i] and gnt[i] are both high.
  - Deasserting req before grant is legal; nothing is issued for it.
- Arbitration:
  - gnt is zero when req is zero; otherwise exactly one bit is set.
  - Round-robin: the search starts at last_gnt+1 modulo N_REQ and picks the first set req bit.
  - last_gnt updates to the winner on every transfer. It holds when no request is present.
  - Reset value of last_gnt is N_REQ-1, so requester 0 has first priority after reset.
- Issue: on a transfer, rom_addr <= req_addr[winner]. With no transfer, rom_addr holds its value.
- Response pipeline:
  - A 2-stage shift register carries {valid, id}.
  - Stage 1 loads {transfer, winner}. Stage 2 loads stage 1.
  - rsp_valid and rsp_id are driven from stage 2.
- busy = stage1.valid | stage2.valid.
- Requesters with index ≥ N_REQ do not exist; their bits are never granted.
- Address width rules:
  - rom_addr is passed through unmodified; no bounds check.
  - Addresses above 999 return whatever the ROM holds.
- Reset, asserted at any time:
  - gnt = 0.
  - rom_addr = 0.
  - Both pipeline stages are cleared, so rsp_valid = 0 and rsp_id = 0; in-flight responses are dropped, not delivered.
  - busy = 0.
  - last_gnt = N_REQ-1.

## Timing
- Cycle t: req[i] high, gnt[i] high combinationally.
- Edge ending t: rom_addr is loaded.
- Edge ending t+1: the ROM samples rom_addr.
- Cycle t+2: rsp_valid = 1, rsp_id = i, and rsp_data carries the word.
- Latency is therefore 2 cycles from grant to response.
- Throughput is one grant per cycle. Back-to-back grants to different requesters produce back-to-back responses in grant order.
- Simultaneous events:
  - All requesters high: requesters are served in rotating order, each at least once every N_REQ cycles.
  - A single requester held high continuously is granted every cycle.
- gnt depends combinationally on req and last_gnt only; there is no combinational path from rom_data.

## Configuration
- NUMBER_ROM_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. The lowest set req index always wins, last_gnt is not implemented, and starvation of high indices is accepted.
  - Undefined (default): round-robin as described above.
- Latency and the handshake are identical in both builds.

## Test plan
- Reset: hold reset_n=0 with req=4'b1111. Require gnt=0, rom_addr=0, rsp_valid=0, busy=0. Release reset; the first grant goes to requester 0.
- Single requester: req=4'b0100 with address 10'd305 for 1 cycle. Require gnt=4'b0100 that cycle, then rom_addr=305, then rsp_valid=1, rsp_id=2 and rsp_data equal to ROM[305] exactly 2 cycles after grant.
- Full contention: req=4'b1111 held for 8 cycles (round-robin). Require the grant sequence 0,1,2,3,0,1,2,3 and rsp_id following the same sequence delayed by 2 cycles.
- Full contention, fixed-priority build: same stimulus with the macro defined. Require gnt=4'b0001 on all 8 cycles.
- Gap handling: req=4'b1000 for 1 cycle, then idle for 2 cycles, then req=4'b0001. Require grant 3 then grant 0, and rom_addr holding 3's address during the idle cycles.
- Mid-flight reset: grant requester 1, then assert reset_n=0 one cycle later. Require rsp_valid never pulses and busy=0 immediately.
